mem_arbiter: RTL and testbench

- Shares one single-outstanding memory bus between the instruction-fetch port (pcF/instrF) and the data port (aluoutM/writedataM/memwriteEN/readdataM) of the 5-stage MIPS core.
- Sits between mips and the memory/bus bridge.
- Serialises the two requesters, data first, and latches each response.
- Drives one global stall back to the pipeline until every request for the current cycle is satisfied.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_port_latch.sv | 45 ++++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state encoding and
// port selection.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDReq  = 3'd1,
    StDWait = 3'd2,
    StIReq  = 3'd3,
    StIWait = 3'd4
  } arb_state_e;

  typedef enum logic {
    PortInst = 1'b0,
    PortData = 1'b1
  } arb_port_e;

  // Which requester owns the bus in a given state (IDLE reports inst, unused there).
  function automatic arb_port_e state_port(arb_state_e st);
    return (st == StDReq || st == StDWait) ? PortData : PortInst;
  endfunction

endpackage

// File: rtl/arb_port_latch.sv
// Per-requester completion flag and response register; the response holds
// until the next read for this port overwrites it.
module arb_port_latch #(
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             set_i,
  input  logic             clear_i,
  input  logic             capture_en_i,
  input  logic [DataW-1:0] rdata_i,
  output logic             done_o,
  output logic [DataW-1:0] rdata_o
);

  logic             done_q, done_d;
  logic [DataW-1:0] rdata_q, rdata_d;

  always_comb begin
    done_d  = done_q;
    rdata_d = rdata_q;
    if (set_i) begin
      done_d = 1'b1;
    end else if (clear_i) begin
      done_d = 1'b0;
    end
    if (set_i && capture_en_i) begin
      rdata_d = rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign done_o  = done_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises MIPS instruction-fetch and data accesses onto one single-outstanding
// memory bus, data first, and stalls the pipeline until every request is served.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  input  logic                flush,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_data_ok
);

  arb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                wr_q, wr_d;
  logic                orphan_q, orphan_d;

  logic inst_done, data_done;
  logic in_wait, pending_inst, pending_data, served, latch_clear;

  assign in_wait      = (state_q == StDWait) || (state_q == StIWait);
  assign pending_inst = inst_req & ~inst_done;
  assign pending_data = data_req & ~data_done;
  // A flushed transaction still owns the bus until its data_ok arrives.
  assign stall        = rst & ~flush & (pending_inst | pending_data | (orphan_q & in_wait));
  assign served       = in_wait & mem_data_ok & ~orphan_q & ~flush;
  assign latch_clear  = ~stall | flush;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wr_d     = wr_q;
    orphan_d = orphan_q;
    unique case (state_q)
      StIdle: begin
        orphan_d = 1'b0;
        if (!flush && pending_data) begin
          state_d = StDReq;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          wstrb_d = data_wen;
          wr_d    = |data_wen;
        end else if (!flush && pending_inst) begin
          state_d = StIReq;
          addr_d  = inst_addr;
          wdata_d = '0;
          wstrb_d = '0;
          wr_d    = 1'b0;
        end
      end
      StDReq, StIReq: begin
        if (mem_addr_ok) begin
          state_d  = (state_q == StDReq) ? StDWait : StIWait;
          orphan_d = flush;
        end else if (flush) begin
          state_d = StIdle;
        end
      end
      StDWait, StIWait: begin
        if (flush) orphan_d = 1'b1;
        if (mem_data_ok) begin
          state_d  = StIdle;
          orphan_d = 1'b0;
          // Chain straight into a waiting fetch to avoid an idle bubble.
          if (state_q == StDWait && !orphan_q && !flush && pending_inst) begin
            state_d = StIReq;
            addr_d  = inst_addr;
            wdata_d = '0;
            wstrb_d = '0;
            wr_d    = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wr_q     <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wr_q     <= wr_d;
      orphan_q <= orphan_d;
    end
  end

  assign mem_req   = (state_q == StDReq) || (state_q == StIReq);
  assign mem_wr    = wr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  arb_port_latch #(
    .DataW (DATA_W)
  ) u_inst_latch (
    .clk_i        (clk),
    .rst_ni       (rst),
    .set_i        (served && state_port(state_q) == PortInst),
    .clear_i      (latch_clear),
    .capture_en_i (1'b1),
    .rdata_i      (mem_rdata),
    .done_o       (inst_done),
    .rdata_o      (inst_rdata)
  );

  arb_port_latch #(
    .DataW (DATA_W)
  ) u_data_latch (
    .clk_i        (clk),
    .rst_ni       (rst),
    .set_i        (served && state_port(state_q) == PortData),
    .clear_i      (latch_clear),
    .capture_en_i (~wr_q),
    .rdata_i      (mem_rdata),
    .done_o       (data_done),
    .rdata_o      (data_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-stepped bus responder driven at the
// falling edge, plus a sampler logging every accepted address phase.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, flush;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wen;
  logic [31:0] inst_rdata, data_rdata;
  logic        stall, mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] acc_addr[$];
  logic [31:0] acc_wdata[$];
  logic [3:0]  acc_strb[$];
  logic        acc_wr[$];
  int          stall_cnt;
  bit          busy_seen;
  bit          outstanding = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wen    (data_wen),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .flush       (flush),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_rdata   (mem_rdata),
    .mem_data_ok (mem_data_ok)
  );

  // Sample mid-low-phase, after the falling-edge drives have settled.
  always @(negedge clk) begin
    #2;
    if (mem_req) busy_seen = 1'b1;
    if (busy_seen && stall) stall_cnt++;
    if (rst && mem_req && mem_addr_ok) begin
      acc_addr.push_back(mem_addr);
      acc_wdata.push_back(mem_wdata);
      acc_strb.push_back(mem_wstrb);
      acc_wr.push_back(mem_wr);
      outstanding = 1'b1;
    end
    if (rst && mem_data_ok) begin
      assert (outstanding) else $error("mem_data_ok with no transaction outstanding");
      outstanding = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] addr_at(input int i);
    return (i < acc_addr.size()) ? acc_addr[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic new_test();
    acc_addr.delete();
    acc_wdata.delete();
    acc_strb.delete();
    acc_wr.delete();
    stall_cnt = 0;
    busy_seen = 1'b0;
  endtask

  // Called at a falling edge; serves one transaction, data_ok in the first wait cycle.
  task automatic serve(input int aw, input logic [31:0] rd, output bit stable);
    int t = 0;
    logic [31:0] a0;
    stable = 1'b1;
    while (!mem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!mem_req) begin
      check_eq("bus_request_timeout", {31'd0, mem_req}, 32'd1);
      return;
    end
    a0 = mem_addr;
    for (int i = 0; i < aw; i++) begin
      mem_addr_ok = 1'b0;
      @(negedge clk);
      if (!(mem_req && mem_addr == a0)) stable = 1'b0;
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    @(negedge clk);
    mem_data_ok = 1'b0;
  endtask

  bit st;

  initial begin
    rst = 1'b0;
    {inst_req, data_req, flush, mem_addr_ok, mem_data_ok} = '0;
    inst_addr = '0; data_addr = '0; data_wdata = '0; data_wen = '0; mem_rdata = '0;
    #1;
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_inst_rdata", inst_rdata, 32'd0);
    check_eq("rst_data_rdata", data_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Load only, zero-wait memory.
    new_test();
    data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h0000_1004;
    #1 check_eq("load_stall_on_req", {31'd0, stall}, 32'd1);
    serve(0, 32'hDEAD_BEEF, st);
    #3;
    check_eq("load_stall_cycles", stall_cnt, 32'd2);
    check_eq("load_stall_low", {31'd0, stall}, 32'd0);
    check_eq("load_rdata", data_rdata, 32'hDEAD_BEEF);
    check_eq("load_bus_addr", addr_at(0), 32'h0000_1004);
    check_eq("load_bus_wr", (acc_wr.size() == 1) ? {31'd0, acc_wr[0]} : 32'hFFFF, 32'd0);
    @(negedge clk);
    data_req = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous store and fetch: store goes first.
    new_test();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h0000_0100; data_wdata = 32'h1234_5678;
    serve(0, 32'h5555_5555, st);
    serve(0, 32'hCAFE_F00D, st);
    #3;
    check_eq("both_n_trans", acc_addr.size(), 32'd2);
    check_eq("both_first_addr", addr_at(0), 32'h0000_0100);
    check_eq("both_first_wr", (acc_wr.size() == 2) ? {31'd0, acc_wr[0]} : 32'hFFFF, 32'd1);
    check_eq("both_first_strb", (acc_strb.size() == 2) ? {28'd0, acc_strb[0]} : 32'hFFFF, 32'h3);
    check_eq("both_first_wdata", (acc_wdata.size() == 2) ? acc_wdata[0] : 32'hFFFF, 32'h1234_5678);
    check_eq("both_second_addr", addr_at(1), 32'hBFC0_0000);
    check_eq("both_second_wr", (acc_wr.size() == 2) ? {31'd0, acc_wr[1]} : 32'hFFFF, 32'd0);
    check_eq("both_stall_cycles", stall_cnt, 32'd4);
    check_eq("both_inst_rdata", inst_rdata, 32'hCAFE_F00D);
    check_eq("both_store_no_capture", data_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b0; data_wen = 4'b0000;
    repeat (2) @(negedge clk);

    // Back-pressure: address phase held off for 3 cycles.
    new_test();
    data_req = 1'b1; data_addr = 32'h0000_2000;
    serve(3, 32'hA5A5_0001, st);
    #3;
    check_eq("bp_addr_stable", {31'd0, st}, 32'd1);
    check_eq("bp_stall_cycles", stall_cnt, 32'd5);
    check_eq("bp_rdata", data_rdata, 32'hA5A5_0001);
    @(negedge clk);
    data_req = 1'b0;
    repeat (2) @(negedge clk);

    // Flush during fetch wait: orphan completes without updating inst_rdata.
    new_test();
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    @(negedge clk);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    flush = 1'b1;
    #1 check_eq("fl_stall_forced_low", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0; inst_addr = 32'h0000_0080;
    #1 check_eq("fl_stall_orphan", {31'd0, stall}, 32'd1);
    check_eq("fl_no_req_orphan", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1 check_eq("fl_rdata_kept", inst_rdata, 32'hCAFE_F00D);
    check_eq("fl_done_clear_stall", {31'd0, stall}, 32'd1);
    check_eq("fl_no_req_idle", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check_eq("fl_refetch_req", {31'd0, mem_req}, 32'd1);
    check_eq("fl_refetch_addr", mem_addr, 32'h0000_0080);
    serve(0, 32'h2222_2222, st);
    #3;
    check_eq("fl_refetch_rdata", inst_rdata, 32'h2222_2222);
    check_eq("fl_n_trans", acc_addr.size(), 32'd2);
    @(negedge clk);
    inst_req = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a data wait.
    new_test();
    data_req = 1'b1; data_addr = 32'h0000_3000;
    @(negedge clk);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    #3 rst = 1'b0;
    #1;
    check_eq("ar_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("ar_stall", {31'd0, stall}, 32'd0);
    check_eq("ar_mem_addr", mem_addr, 32'd0);
    check_eq("ar_inst_rdata", inst_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1; data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0500;
    serve(0, 32'h0BAD_F00D, st);
    #3;
    check_eq("ar_fetch_addr", addr_at(1), 32'h0000_0500);
    check_eq("ar_fetch_rdata", inst_rdata, 32'h0BAD_F00D);
    @(negedge clk);
    inst_req = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back fetches, pc advancing on each stall-free edge.
    new_test();
    inst_req = 1'b1; inst_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      serve(0, 32'h0000_0100 + k, st);
      check_eq($sformatf("b2b_rdata_%0d", k), inst_rdata, 32'h0000_0100 + k);
      inst_addr = 32'(4 * (k + 1));
    end
    inst_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("b2b_n_trans", acc_addr.size(), 32'd3);
    check_eq("b2b_addr0", addr_at(0), 32'h0);
    check_eq("b2b_addr1", addr_at(1), 32'h4);
    check_eq("b2b_addr2", addr_at(2), 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
